vgen_fmt: RTL
=============

# vgen_fmt

Parametrised video frame generator. Streams a sequence of pre-rendered frames from SPI flash through the SPI reader and writes them row by row into the frame buffer's write port. Sits between the SPI reader and the frame buffer write side. Adds the following:
- selectable pixel format (RGB565 or RGB888);
- runtime-programmable frame hold count;
- pause;
- one-shot or loop playback.

## Interface
Parameters:
- ADDR_BASE, 24'h040000, flash byte address of frame 0, row 0
- N_FRAMES, 30, number of frames in the sequence (≥1)
- N_ROWS, 64, rows per frame (power of 2)
- N_COLS, 64, pixels per row (power of 2)
- BPP, 16, bits per pixel in flash; 16 (RGB565) or 24 (RGB888)
- REP_W, 8, width of the hold-count config
- LOG_N_ROWS / LOG_N_COLS, $clog2 of N_ROWS / N_COLS (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_rep  in  REP_W  each frame is presented cfg_rep+1 times
- cfg_oneshot  in  1  1 = stop after last frame; 0 = loop
- cfg_pause  in  1  1 = hold before starting the next frame
- sr_addr  out  24  flash read address
- sr_len  out  16  read length − 1
- sr_go  out  1  read start strobe
- sr_rdy  in  1  reader idle
- sr_data  in  8  read byte
- sr_valid  in  1  byte strobe
- fbw_row_addr  out  LOG_N_ROWS  row being written
- fbw_row_store  out  1  commit row to back buffer
- fbw_row_swap  out  1  swap line buffer
- fbw_row_rdy  in  1  frame buffer can accept store
- fbw_data  out  24  RGB888 pixel
- fbw_col_addr  out  LOG_N_COLS  pixel column
- fbw_wren  out  1  pixel write strobe
- frame_swap  out  1  present completed frame
- frame_rdy  in  1  frame buffer can take a new frame
- frame_idx  out  $clog2(N_FRAMES)+1  current frame number
- done  out  1  one-shot playback finished

## Operation
- Derived constants:
  - BYTES = BPP/8
  - ROW_BYTES = N_COLS·BYTES
  - FRAME_BYTES = N_ROWS·ROW_BYTES
  - sr_len = ROW_BYTES−1 (constant)
- Addressing uses no multiplier:
  - frame_base register: starts at ADDR_BASE; adds FRAME_BYTES on frame advance; returns to ADDR_BASE on wrap.
  - row_addr register: loads frame_base in FRAME_WAIT; adds ROW_BYTES per committed row.
  - sr_addr = row_addr.
- FSM states: FRAME_WAIT, SPI_CMD, SPI_READ, ROW_WRITE, ROW_WAIT, DONE.
  - FRAME_WAIT → SPI_CMD when frame_rdy & sr_rdy & !cfg_pause.
  - SPI_CMD → SPI_READ unconditionally; sr_go = 1 for this single cycle.
  - SPI_READ → ROW_WRITE when sr_rdy.
  - ROW_WRITE → on fbw_row_rdy: ROW_WAIT if last row, else SPI_CMD.
  - ROW_WAIT → on fbw_row_rdy: DONE if one-shot end condition, else FRAME_WAIT.
  - DONE → FRAME_WAIT when cfg_oneshot = 0. On that exit, frame_idx and frame_base are set to 0 / ADDR_BASE and the hold counter is cleared.
- Pixel assembly:
  - The byte counter and column counter clear whenever state ≠ SPI_READ.
  - Each sr_valid shifts sr_data in. The byte index wraps at BYTES.
  - fbw_wren = sr_valid & (byte index == BYTES−1).
  - fbw_col_addr = column counter. The counter increments on each fbw_wren.
  - Bytes beyond N_COLS pixels never assert fbw_wren.
- RGB565 format:
  - Byte order: low byte first. p = {b1, b0}.
  - fbw_data = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]}.
- RGB888 format:
  - Byte order: R, G, B.
  - fbw_data = {b0, b1, b2}.
- Frame advance (ROW_WAIT & fbw_row_rdy):
  - frame_swap, fbw_row_store and fbw_row_swap are combinational, matching the transition conditions.
  - If hold counter ≥ cfg_rep: clear the hold counter and advance the frame; otherwise increment the hold counter.
  - Using ≥ means that lowering cfg_rep mid-hold ends the current hold at the next presentation.
  - Advancing past frame N_FRAMES−1: if cfg_oneshot, go to DONE, with frame_idx kept at N_FRAMES−1. Otherwise wrap frame_idx to 0.
- done = (state == DONE).
- cfg_pause is sampled only in FRAME_WAIT. A row or frame already in progress always completes.

## Timing
- Reset values:
  - state FRAME_WAIT; frame_idx 0; hold counter 0; row counter 0.
  - row_addr = frame_base = ADDR_BASE.
  - sr_go, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap and done are all 0.
  - Reset mid-row aborts immediately. Partially written row data is discarded; the next frame starts at frame 0.
- sr_go is a 1-cycle pulse. The reader drops sr_rdy the cycle after sr_go, so SPI_READ always lasts ≥1 cycle.
- fbw_wren is combinational from sr_valid, with zero latency. fbw_data is valid in the same cycle.
- fbw_row_addr holds the row number throughout SPI_READ and ROW_WRITE. It increments the cycle after the store.
- Minimum per row: 3 cycles + ROW_BYTES byte strobes + fbw_row_rdy wait.

## Test plan
- RGB565, N_ROWS = 4, N_COLS = 4, byte stream 0x1F,0xF8 → fbw_data = 0xFF00FF at col 0. wren occurs once every 2 valid bytes. sr_len = 7; sr_addr for rows = 0x040000, 0x040008, 0x040010, 0x040018.
- BPP = 24, N_COLS = 4: bytes 0x12,0x34,0x56 → fbw_data = 0x123456. sr_len = 11. Frame 1 row 0 sr_addr = 0x040000 + 48 = 0x040030.
- cfg_rep = 2, N_FRAMES = 3, loop: frame_idx sequence across frame_swaps is 0,0,0,1,1,1,2,2,2,0. After the wrap, sr_addr returns to 0x040000.
- cfg_oneshot = 1, cfg_rep = 0, N_FRAMES = 2: after 2 frame_swaps, done = 1 and sr_go stays 0. Deasserting cfg_oneshot → next sr_addr = ADDR_BASE and frame_idx = 0.
- cfg_pause raised mid-row: the row and frame complete, including frame_swap. The FSM then holds in FRAME_WAIT with no sr_go; releasing pause resumes at the next frame.
- rst asserted during SPI_READ of row 2: all strobes are 0 that cycle. After release, the first sr_addr = ADDR_BASE and fbw_row_addr = 0.

Source files
------------

// File: rtl/vgen_fmt.sv
// Video frame generator: fetches pre-rendered frames row by row from SPI flash,
// converts RGB565/RGB888 pixels to RGB888 and streams them into the frame buffer.
module vgen_fmt #(
    parameter logic [23:0] ADDR_BASE  = 24'h040000,
    parameter int          N_FRAMES   = 30,
    parameter int          N_ROWS     = 64,
    parameter int          N_COLS     = 64,
    parameter int          BPP        = 16,
    parameter int          REP_W      = 8,
    parameter int          LOG_N_ROWS = $clog2(N_ROWS),
    parameter int          LOG_N_COLS = $clog2(N_COLS),
    parameter int          FIDX_W     = $clog2(N_FRAMES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REP_W-1:0]      cfg_rep,
    input  logic                  cfg_oneshot,
    input  logic                  cfg_pause,
    output logic [23:0]           sr_addr,
    output logic [15:0]           sr_len,
    output logic                  sr_go,
    input  logic                  sr_rdy,
    input  logic [7:0]            sr_data,
    input  logic                  sr_valid,
    output logic [LOG_N_ROWS-1:0] fbw_row_addr,
    output logic                  fbw_row_store,
    output logic                  fbw_row_swap,
    input  logic                  fbw_row_rdy,
    output logic [23:0]           fbw_data,
    output logic [LOG_N_COLS-1:0] fbw_col_addr,
    output logic                  fbw_wren,
    output logic                  frame_swap,
    input  logic                  frame_rdy,
    output logic [FIDX_W-1:0]     frame_idx,
    output logic                  done
);

    localparam int BYTES       = BPP / 8;
    localparam int ROW_BYTES   = N_COLS * BYTES;
    localparam int FRAME_BYTES = N_ROWS * ROW_BYTES;
    localparam int SH_W        = (BYTES - 1) * 8;

    typedef enum logic [2:0] {
        FRAME_WAIT, SPI_CMD, SPI_READ, ROW_WRITE, ROW_WAIT, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [FIDX_W-1:0]     frame_idx_q, frame_idx_d;
    logic [REP_W-1:0]      hold_q, hold_d;
    logic [23:0]           frame_base_q, frame_base_d;
    logic [23:0]           row_addr_q;
    logic [LOG_N_ROWS-1:0] row_q;
    logic [1:0]            byte_q;
    logic [LOG_N_COLS:0]   col_q;
    logic [SH_W-1:0]       sh_q;

    logic in_read, row_commit, frame_end, last_row, last_frame, hold_done;
    logic [BPP-1:0] px;

    assign in_read    = (state_q == SPI_READ);
    assign row_commit = (state_q == ROW_WRITE) && fbw_row_rdy;
    assign frame_end  = (state_q == ROW_WAIT) && fbw_row_rdy;
    assign last_row   = &row_q;
    assign last_frame = (frame_idx_q == FIDX_W'(N_FRAMES - 1));
    assign hold_done  = (hold_q >= cfg_rep);

    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        frame_idx_d  = frame_idx_q;
        hold_d       = hold_q;
        frame_base_d = frame_base_q;
        case (state_q)
            FRAME_WAIT: if (frame_rdy && sr_rdy && !cfg_pause) state_d = SPI_CMD;
            SPI_CMD:    state_d = SPI_READ;
            SPI_READ:   if (sr_rdy) state_d = ROW_WRITE;
            ROW_WRITE:  if (fbw_row_rdy) state_d = last_row ? ROW_WAIT : SPI_CMD;
            ROW_WAIT: begin
                if (fbw_row_rdy) begin
                    state_d = FRAME_WAIT;
                    if (hold_done) begin
                        hold_d = '0;
                        if (!last_frame) begin
                            frame_idx_d  = frame_idx_q + 1'b1;
                            frame_base_d = frame_base_q + 24'(FRAME_BYTES);
                        end else if (cfg_oneshot) begin
                            state_d = DONE;
                        end else begin
                            frame_idx_d  = '0;
                            frame_base_d = ADDR_BASE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!cfg_oneshot) begin
                    state_d      = FRAME_WAIT;
                    frame_idx_d  = '0;
                    frame_base_d = ADDR_BASE;
                    hold_d       = '0;
                end
            end
            default: state_d = FRAME_WAIT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FRAME_WAIT;
            frame_idx_q  <= '0;
            hold_q       <= '0;
            frame_base_q <= ADDR_BASE;
            row_addr_q   <= ADDR_BASE;
            row_q        <= '0;
            byte_q       <= '0;
            col_q        <= '0;
            sh_q         <= '0;
        end else begin
            state_q      <= state_d;
            frame_idx_q  <= frame_idx_d;
            hold_q       <= hold_d;
            frame_base_q <= frame_base_d;

            if (state_q == FRAME_WAIT) row_addr_q <= frame_base_q;
            else if (row_commit)       row_addr_q <= row_addr_q + 24'(ROW_BYTES);

            if (row_commit) row_q <= row_q + 1'b1;

            if (!in_read) begin
                byte_q <= '0;
                col_q  <= '0;
            end else if (sr_valid) begin
                byte_q <= (byte_q == 2'(BYTES - 1)) ? 2'd0 : byte_q + 2'd1;
                sh_q   <= SH_W'({sh_q, sr_data});
                if (fbw_wren) col_q <= col_q + 1'b1;
            end
        end
    end

    // Earlier bytes of the pixel sit in sh_q; the final byte is used live.
    assign px = {sh_q, sr_data};

    generate
        if (BPP == 24) begin : g_rgb888
            assign fbw_data = px;
        end else begin : g_rgb565
            logic [15:0] p;
            assign p        = {px[7:0], px[15:8]};
            assign fbw_data = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
        end
    endgenerate

    assign fbw_wren      = in_read && sr_valid && (byte_q == 2'(BYTES - 1)) && !col_q[LOG_N_COLS];
    assign fbw_col_addr  = col_q[LOG_N_COLS-1:0];
    assign fbw_row_addr  = row_q;
    assign fbw_row_store = row_commit;
    assign fbw_row_swap  = row_commit;
    assign frame_swap    = frame_end;
    assign sr_go         = (state_q == SPI_CMD);
    assign sr_addr       = row_addr_q;
    assign sr_len        = 16'(ROW_BYTES - 1);
    assign frame_idx     = frame_idx_q;
    assign done          = (state_q == DONE);

endmodule
